clock_set_ctrl: RTL and testbench

CLOCK_SET_CTRL -- requirements
Module: clock_set_ctrl

---
 rtl/clock_set_ctrl.sv | 162 ++++++++++++++++
 tb/tb_clock_set_ctrl.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clock_set_ctrl.sv
// clock_set_ctrl: set-mode FSM that edits shadow time/date values and commits them to the live counters
module clock_set_ctrl #(
    parameter int BLINK_HALF = 25000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_mode,
    input  logic       btn_next,
    input  logic       btn_inc,
    input  logic       btn_dec,
    input  logic       sel,
    input  logic [5:0] cur_sec,
    input  logic [5:0] cur_min,
    input  logic [5:0] cur_hour,
    input  logic [5:0] cur_day,
    input  logic [5:0] cur_month,
    input  logic [9:0] cur_year,
    output logic       set_mode,
    output logic [1:0] set_select,
    output logic       blink,
    output logic       load,
    output logic [5:0] new_sec,
    output logic [5:0] new_min,
    output logic [5:0] new_hour,
    output logic [5:0] new_day,
    output logic [5:0] new_month,
    output logic [9:0] new_year
);
    localparam int CW = BLINK_HALF > 1 ? $clog2(BLINK_HALF) : 1;
    typedef enum logic [1:0] {IDLE, EDIT, COMMIT} state_t;
    state_t state_q, state_d;
    logic [3:0] btn_q, btn_d, btn_in, e;
    logic arm_q, arm_d, set_mode_q, set_mode_d, blink_q, blink_d, load_q, load_d;
    logic [1:0] sel_idx_q, sel_idx_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [5:0] sec_q, sec_d, min_q, min_d, hour_q, hour_d, day_q, day_d, mon_q, mon_d, dm;
    logic [9:0] year_q, year_d;
    logic up, dn, f0, f1, f2;
    // Wrapping step of v within lo..hi; out-of-range values wrap as if at the bound
    function automatic logic [9:0] step(input logic [9:0] v, input logic [9:0] lo,
                                        input logic [9:0] hi, input logic u, input logic d);
        return u ? (v >= hi ? lo : v + 10'd1) : d ? (v <= lo ? hi : v - 10'd1) : v;
    endfunction
    // Days in month m of calendar year y + 2025
    function automatic logic [5:0] dmax(input logic [5:0] m, input logic [9:0] y);
        logic [11:0] yy;
        logic leap;
        yy = {2'b00, y} + 12'd2025;
        leap = (yy[1:0] == 2'b00) && ((yy % 12'd100 != 12'd0) || (yy % 12'd400 == 12'd0));
        return m == 6'd2 ? (leap ? 6'd29 : 6'd28) :
               (m == 6'd4 || m == 6'd6 || m == 6'd9 || m == 6'd11) ? 6'd30 : 6'd31;
    endfunction
    // Edges are gated by arm_q so a button held through reset release is not seen as pressed
    assign btn_in = {btn_mode, btn_next, btn_inc, btn_dec};
    assign e = btn_in & ~btn_q & {4{arm_q}};
    assign up = e[1] & ~e[0];
    assign dn = e[0] & ~e[1];
    assign f0 = sel_idx_q == 2'd0;
    assign f1 = sel_idx_q == 2'd1;
    assign f2 = sel_idx_q == 2'd2;
    // Next-state: mode handling, field editing with wrap and day clamp, blink timing
    always_comb begin
        state_d = state_q;
        btn_d = btn_in;
        arm_d = 1'b1;
        set_mode_d = set_mode_q;
        sel_idx_d = sel_idx_q;
        blink_d = blink_q;
        cnt_d = cnt_q;
        load_d = 1'b0;
        sec_d = sec_q;
        min_d = min_q;
        hour_d = hour_q;
        day_d = day_q;
        mon_d = mon_q;
        year_d = year_q;
        dm = dmax(mon_q, year_q);
        if (state_q == IDLE) begin
            if (e[3]) begin
                state_d = EDIT;
                set_mode_d = 1'b1;
                sel_idx_d = 2'd0;
                cnt_d = '0;
                blink_d = 1'b0;
                sec_d = cur_sec;
                min_d = cur_min;
                hour_d = cur_hour;
                day_d = cur_day;
                mon_d = cur_month;
                year_d = cur_year;
            end
        end else if (state_q == EDIT) begin
            if (e[3]) begin
                state_d = COMMIT;
                load_d = 1'b1;
                blink_d = 1'b0;
            end else begin
                cnt_d = cnt_q == CW'(BLINK_HALF - 1) ? '0 : cnt_q + CW'(1);
                blink_d = cnt_q == CW'(BLINK_HALF - 1) ? ~blink_q : blink_q;
                sel_idx_d = e[2] ? (f2 ? 2'd0 : sel_idx_q + 2'd1) : sel_idx_q;
                if (!sel) begin
                    sec_d = 6'(step({4'b0, sec_q}, 10'd0, 10'd59, up & f0, dn & f0));
                    min_d = 6'(step({4'b0, min_q}, 10'd0, 10'd59, up & f1, dn & f1));
                    hour_d = 6'(step({4'b0, hour_q}, 10'd0, 10'd23, up & f2, dn & f2));
                end else begin
                    mon_d = 6'(step({4'b0, mon_q}, 10'd1, 10'd12, up & f1, dn & f1));
                    year_d = step(year_q, 10'd0, 10'd974, up & f2, dn & f2);
                    dm = dmax(mon_d, year_d);
                    day_d = 6'(step({4'b0, day_q}, 10'd1, {4'b0, dm}, up & f0, dn & f0));
                    if ((f1 | f2) && (up | dn) && day_q > dm) day_d = dm;
                end
            end
        end else begin
            state_d = IDLE;
            set_mode_d = 1'b0;
        end
    end
    // State and registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            btn_q <= '0;
            arm_q <= 1'b0;
            set_mode_q <= 1'b0;
            sel_idx_q <= 2'd0;
            blink_q <= 1'b0;
            cnt_q <= '0;
            load_q <= 1'b0;
            sec_q <= 6'd0;
            min_q <= 6'd0;
            hour_q <= 6'd0;
            day_q <= 6'd1;
            mon_q <= 6'd1;
            year_q <= 10'd0;
        end else begin
            state_q <= state_d;
            btn_q <= btn_d;
            arm_q <= arm_d;
            set_mode_q <= set_mode_d;
            sel_idx_q <= sel_idx_d;
            blink_q <= blink_d;
            cnt_q <= cnt_d;
            load_q <= load_d;
            sec_q <= sec_d;
            min_q <= min_d;
            hour_q <= hour_d;
            day_q <= day_d;
            mon_q <= mon_d;
            year_q <= year_d;
        end
    end
    assign set_mode = set_mode_q;
    assign set_select = sel_idx_q;
    assign blink = blink_q;
    assign load = load_q;
    assign new_sec = sec_q;
    assign new_min = min_q;
    assign new_hour = hour_q;
    assign new_day = day_q;
    assign new_month = mon_q;
    assign new_year = year_q;
endmodule

// File: tb/tb_clock_set_ctrl.sv
// tb_clock_set_ctrl: scenario tasks plus a load-pulse scoreboard for clock_set_ctrl
module tb_clock_set_ctrl;
    localparam logic [3:0] MODE = 4'b1000, NEXT = 4'b0100, INC = 4'b0010, DEC = 4'b0001;
    typedef struct packed {
        logic [5:0] s, m, h, d, mo;
        logic [9:0] y;
    } exp_t;
    logic clk = 1'b0, rst_n = 1'b0, sel = 1'b0;
    logic [3:0] btn = 4'b0;
    logic [5:0] cur_sec = 0, cur_min = 0, cur_hour = 0, cur_day = 1, cur_month = 1;
    logic [9:0] cur_year = 0;
    logic set_mode, blink, load;
    logic [1:0] set_select;
    logic [5:0] new_sec, new_min, new_hour, new_day, new_month;
    logic [9:0] new_year;
    exp_t sb[$];
    exp_t got, want;
    int n_cmp = 0, n_err = 0;

    clock_set_ctrl #(.BLINK_HALF(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .btn_mode(btn[3]), .btn_next(btn[2]), .btn_inc(btn[1]), .btn_dec(btn[0]),
        .sel(sel),
        .cur_sec(cur_sec), .cur_min(cur_min), .cur_hour(cur_hour),
        .cur_day(cur_day), .cur_month(cur_month), .cur_year(cur_year),
        .set_mode(set_mode), .set_select(set_select), .blink(blink), .load(load),
        .new_sec(new_sec), .new_min(new_min), .new_hour(new_hour),
        .new_day(new_day), .new_month(new_month), .new_year(new_year)
    );

    always #5 clk = ~clk;

    // Every load pulse must match the oldest expected commit
    always @(negedge clk) begin
        if (rst_n && load === 1'b1) begin
            n_cmp++;
            got = {new_sec, new_min, new_hour, new_day, new_month, new_year};
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL load_unexpected got load=1 with %h, required no load", got);
            end else begin
                want = sb.pop_front();
                if (got !== want) begin
                    n_err++;
                    $display("FAIL load_values got %h required %h", got, want);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout simulation did not finish");
        $fatal(1);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [3:0] b);
        btn = b;
        tick();
        btn = 4'b0;
        tick();
    endtask

    task automatic set_cur(input logic [5:0] s, input logic [5:0] m, input logic [5:0] h,
                           input logic [5:0] d, input logic [5:0] mo, input logic [9:0] y);
        cur_sec = s; cur_min = m; cur_hour = h; cur_day = d; cur_month = mo; cur_year = y;
    endtask

    task automatic commit(input exp_t e);
        sb.push_back(e);
        press(MODE);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        btn = MODE;
        repeat (3) tick();
        n_cmp++;
        if ({set_mode, set_select, blink, load} !== 5'b0 ||
            {new_sec, new_min, new_hour, new_day, new_month, new_year} !== {6'd0, 6'd0, 6'd0, 6'd1, 6'd1, 10'd0}) begin
            n_err++;
            $display("FAIL reset_state got ctl=%b vals=%0d/%0d/%0d %0d/%0d/%0d required ctl=0 vals=0/0/0 1/1/0",
                     {set_mode, set_select, blink, load}, new_sec, new_min, new_hour, new_day, new_month, new_year);
        end
        rst_n = 1'b1;
        repeat (3) tick();
        n_cmp++;
        if (set_mode !== 1'b0) begin
            n_err++;
            $display("FAIL held_button_edge got set_mode=%b required 0", set_mode);
        end
        btn = 4'b0;
        repeat (2) tick();
    endtask

    task automatic test_entry_commit;
        set_cur(56, 34, 12, 15, 6, 3);
        sel = 1'b0;
        press(MODE);
        n_cmp++;
        if ({set_mode, set_select, new_sec, new_min, new_hour, new_day} !== {1'b1, 2'd0, 6'd56, 6'd34, 6'd12, 6'd15}) begin
            n_err++;
            $display("FAIL entry_copy got mode=%b sel=%0d %0d:%0d:%0d day=%0d required 1 0 12:34:56 day=15",
                     set_mode, set_select, new_hour, new_min, new_sec, new_day);
        end
        press(INC);
        n_cmp++;
        if (new_sec !== 6'd57) begin
            n_err++;
            $display("FAIL entry_inc got sec=%0d required 57", new_sec);
        end
        commit({6'd57, 6'd34, 6'd12, 6'd15, 6'd6, 10'd3});
        n_cmp++;
        if ({set_mode, load} !== 2'b00) begin
            n_err++;
            $display("FAIL commit_exit got mode=%b load=%b required 0 0", set_mode, load);
        end
        cur_sec = 0;
        repeat (5) tick();
        n_cmp++;
        if (new_sec !== 6'd57) begin
            n_err++;
            $display("FAIL idle_hold got sec=%0d required 57", new_sec);
        end
    endtask

    task automatic test_wrap;
        set_cur(0, 59, 23, 15, 6, 3);
        sel = 1'b0;
        press(MODE);
        press(DEC);
        n_cmp++;
        if (new_sec !== 6'd59) begin
            n_err++;
            $display("FAIL sec_wrap_dec got %0d required 59", new_sec);
        end
        press(NEXT);
        press(INC);
        n_cmp++;
        if (new_min !== 6'd0) begin
            n_err++;
            $display("FAIL min_wrap_inc got %0d required 0", new_min);
        end
        press(NEXT);
        n_cmp++;
        if (set_select !== 2'd2) begin
            n_err++;
            $display("FAIL select_two got %0d required 2", set_select);
        end
        press(INC);
        n_cmp++;
        if (new_hour !== 6'd0) begin
            n_err++;
            $display("FAIL hour_wrap_inc got %0d required 0", new_hour);
        end
        press(DEC);
        n_cmp++;
        if (new_hour !== 6'd23) begin
            n_err++;
            $display("FAIL hour_wrap_dec got %0d required 23", new_hour);
        end
        press(NEXT);
        n_cmp++;
        if (set_select !== 2'd0) begin
            n_err++;
            $display("FAIL select_wrap got %0d required 0", set_select);
        end
        commit({6'd59, 6'd0, 6'd23, 6'd15, 6'd6, 10'd3});
    endtask

    task automatic test_clamp;
        int ys[5] = '{3, 0, 75, 375, 71};
        int dms[5] = '{29, 28, 28, 29, 29};
        sel = 1'b1;
        for (int i = 0; i < 5; i++) begin
            set_cur(0, 0, 0, 31, 1, 10'(ys[i]));
            press(MODE);
            press(NEXT);
            press(INC);
            n_cmp++;
            if ({new_month, new_day} !== {6'd2, 6'(dms[i])}) begin
                n_err++;
                $display("FAIL month_clamp year=%0d got month=%0d day=%0d required 2 %0d",
                         ys[i], new_month, new_day, dms[i]);
            end
            commit({6'd0, 6'd0, 6'd0, 6'(dms[i]), 6'd2, 10'(ys[i])});
        end
        set_cur(0, 0, 0, 29, 2, 3);
        press(MODE);
        press(NEXT);
        press(NEXT);
        press(INC);
        n_cmp++;
        if ({new_year, new_day} !== {10'd4, 6'd28}) begin
            n_err++;
            $display("FAIL year_clamp got year=%0d day=%0d required 4 28", new_year, new_day);
        end
        press(DEC);
        n_cmp++;
        if ({new_year, new_day} !== {10'd3, 6'd28}) begin
            n_err++;
            $display("FAIL year_no_regrow got year=%0d day=%0d required 3 28", new_year, new_day);
        end
        commit({6'd0, 6'd0, 6'd0, 6'd28, 6'd2, 10'd3});
        set_cur(0, 0, 0, 31, 12, 0);
        press(MODE);
        press(NEXT);
        press(INC);
        n_cmp++;
        if ({new_month, new_day} !== {6'd1, 6'd31}) begin
            n_err++;
            $display("FAIL month_wrap got month=%0d day=%0d required 1 31", new_month, new_day);
        end
        press(NEXT);
        press(DEC);
        n_cmp++;
        if (new_year !== 10'd974) begin
            n_err++;
            $display("FAIL year_wrap_dec got %0d required 974", new_year);
        end
        press(INC);
        n_cmp++;
        if (new_year !== 10'd0) begin
            n_err++;
            $display("FAIL year_wrap_inc got %0d required 0", new_year);
        end
        commit({6'd0, 6'd0, 6'd0, 6'd31, 6'd1, 10'd0});
        set_cur(0, 0, 0, 30, 4, 0);
        press(MODE);
        press(INC);
        n_cmp++;
        if (new_day !== 6'd1) begin
            n_err++;
            $display("FAIL day_wrap_inc got %0d required 1", new_day);
        end
        press(DEC);
        n_cmp++;
        if (new_day !== 6'd30) begin
            n_err++;
            $display("FAIL day_wrap_dec got %0d required 30", new_day);
        end
        commit({6'd0, 6'd0, 6'd0, 6'd30, 6'd4, 10'd0});
    endtask

    task automatic test_blink;
        set_cur(1, 2, 3, 4, 5, 6);
        sel = 1'b0;
        repeat (3) tick();
        n_cmp++;
        if (blink !== 1'b0) begin
            n_err++;
            $display("FAIL blink_idle got %b required 0", blink);
        end
        btn = MODE;
        tick();
        btn = 4'b0;
        for (int k = 0; k < 16; k++) begin
            n_cmp++;
            if (blink !== 1'((k / 4) % 2)) begin
                n_err++;
                $display("FAIL blink_phase cycle=%0d got %b required %0d", k, blink, (k / 4) % 2);
            end
            tick();
        end
        sb.push_back({6'd1, 6'd2, 6'd3, 6'd4, 6'd5, 10'd6});
        btn = MODE;
        tick();
        btn = 4'b0;
        n_cmp++;
        if ({set_mode, blink} !== 2'b10) begin
            n_err++;
            $display("FAIL blink_commit got mode=%b blink=%b required 1 0", set_mode, blink);
        end
        tick();
        n_cmp++;
        if ({set_mode, blink} !== 2'b00) begin
            n_err++;
            $display("FAIL blink_after got mode=%b blink=%b required 0 0", set_mode, blink);
        end
    endtask

    task automatic test_simultaneous;
        set_cur(10, 20, 5, 4, 5, 6);
        sel = 1'b0;
        press(MODE);
        press(INC | DEC);
        n_cmp++;
        if ({set_select, new_sec} !== {2'd0, 6'd10}) begin
            n_err++;
            $display("FAIL inc_dec_same got sel=%0d sec=%0d required 0 10", set_select, new_sec);
        end
        press(NEXT | INC);
        n_cmp++;
        if ({set_select, new_sec} !== {2'd1, 6'd11}) begin
            n_err++;
            $display("FAIL next_inc got sel=%0d sec=%0d required 1 11", set_select, new_sec);
        end
        sel = 1'b1;
        tick();
        n_cmp++;
        if ({set_select, new_sec, new_month} !== {2'd1, 6'd11, 6'd5}) begin
            n_err++;
            $display("FAIL page_switch got sel=%0d sec=%0d month=%0d required 1 11 5",
                     set_select, new_sec, new_month);
        end
        sel = 1'b0;
        press(NEXT | DEC);
        n_cmp++;
        if ({set_select, new_min} !== {2'd2, 6'd19}) begin
            n_err++;
            $display("FAIL next_dec got sel=%0d min=%0d required 2 19", set_select, new_min);
        end
        sb.push_back({6'd11, 6'd19, 6'd5, 6'd4, 6'd5, 10'd6});
        press(MODE | INC);
        n_cmp++;
        if (set_mode !== 1'b0) begin
            n_err++;
            $display("FAIL mode_inc_exit got mode=%b required 0", set_mode);
        end
    endtask

    task automatic test_reset_in_edit;
        set_cur(1, 1, 1, 9, 9, 9);
        sel = 1'b0;
        press(MODE);
        press(INC);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        n_cmp++;
        if ({set_mode, set_select, blink, load} !== 5'b0 ||
            {new_sec, new_min, new_hour, new_day, new_month, new_year} !== {6'd0, 6'd0, 6'd0, 6'd1, 6'd1, 10'd0}) begin
            n_err++;
            $display("FAIL reset_in_edit got ctl=%b vals=%0d/%0d/%0d %0d/%0d/%0d required ctl=0 vals=0/0/0 1/1/0",
                     {set_mode, set_select, blink, load}, new_sec, new_min, new_hour, new_day, new_month, new_year);
        end
        repeat (4) tick();
        n_cmp++;
        if ({set_mode, load} !== 2'b00) begin
            n_err++;
            $display("FAIL after_abort got mode=%b load=%b required 0 0", set_mode, load);
        end
    endtask

    initial begin
        test_reset();
        test_entry_commit();
        test_wrap();
        test_clamp();
        test_blink();
        test_simultaneous();
        test_reset_in_edit();
        n_cmp++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL missing_loads got %0d pending required 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end
endmodule
